// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the iterative divider.
//   DIV_WIDTH   default operand width
//   div_state_e divider FSM states (IDLE / BUSY / DONE)
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: execute-stage request/response bundle for div_unit.
//   start      request a division (sampled only while idle)
//   is_signed  1 = DIV, 0 = DIVU
//   opa, opb   dividend, divisor
//   annul      cancel in-flight or starting operation
//   div_stall  stall request to the hazard unit
//   ready      one-cycle result-valid pulse
//   result     {remainder, quotient} = {HI, LO}
// master = execute-stage controller, slave = divider.
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic               annul;
  logic               div_stall;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, is_signed, opa, opb, annul,
    input  div_stall, ready, result
  );

  modport slave (
    input  start, is_signed, opa, opb, annul,
    output div_stall, ready, result
  );
endinterface

// File: rtl/div_unit_step.sv
// div_step: one radix-2 restoring division iteration (combinational).
//   rem_i     partial remainder (always < divisor between steps)
//   quo_i     dividend/quotient shift register
//   divisor_i unsigned divisor magnitude
//   rem_o     updated partial remainder
//   quo_o     updated shift register, new quotient bit in the LSB
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // One extra bit holds the shifted-out remainder MSB; the top bit of the
  // trial difference is then the borrow (negative result).
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_i};
    if (trial[WIDTH]) begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU in the execute stage.
//   clk  pipeline clock, rising edge
//   rst  asynchronous active-high reset
//   bus  div_unit_if slave: start/is_signed/opa/opb/annul in,
//        div_stall/ready/result out ({HI, LO} = {remainder, quotient})
// Latency: start sampled at edge 0, ready pulses in the cycle after edge WIDTH.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  div_unit_if.slave    bus
);
  div_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvsr_q;
  logic [WIDTH-1:0]   opa_raw_q;
  logic               qsign_q;
  logic               rsign_q;
  logic               dz_q;
  logic               ready_q;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH-1:0]   opa_abs;
  logic [WIDTH-1:0]   opb_abs;
  logic [WIDTH-1:0]   rem_n;
  logic [WIDTH-1:0]   quo_n;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               last_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (rem_n),
    .quo_o     (quo_n)
  );

  always_comb begin
    opa_abs   = (bus.is_signed && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
    opb_abs   = (bus.is_signed && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;
    // Sign flags are only ever set for DIV, so DIVU passes straight through.
    quo_fix   = qsign_q ? -quo_n : quo_n;
    rem_fix   = rsign_q ? -rem_n : rem_n;
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      opa_raw_q <= '0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      dz_q      <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          ready_q <= 1'b0;
          if (bus.start && !bus.annul) begin
            rem_q     <= '0;
            quo_q     <= opa_abs;
            dvsr_q    <= opb_abs;
            opa_raw_q <= bus.opa;
            qsign_q   <= bus.is_signed & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
            rsign_q   <= bus.is_signed & bus.opa[WIDTH-1];
            dz_q      <= (bus.opb == '0);
            cnt_q     <= '0;
            state_q   <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (bus.annul) begin
            ready_q <= 1'b0;
            state_q <= DIV_IDLE;
          end else begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + 1'b1;
            if (last_step) begin
              // Final step result is fixed up in the same edge it is produced.
              result_q <= dz_q ? {opa_raw_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
              ready_q  <= 1'b1;
              state_q  <= DIV_DONE;
            end
          end
        end
        DIV_DONE: begin
          ready_q <= 1'b0;
          state_q <= DIV_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  assign bus.div_stall = ((state_q == DIV_IDLE) && bus.start && !bus.annul) ||
                         (state_q == DIV_BUSY);
  assign bus.ready     = ready_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  localparam int unsigned W = 32;
  localparam int LAT = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  logic [63:0] last_exp = '0;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(logic s, logic [31:0] a, logic [31:0] b,
                              logic [63:0] exp, string name);
    vec_t v;
    v.s = s; v.a = a; v.b = b; v.exp = exp; v.name = name;
    return v;
  endfunction

  // Reference: plain 64-bit arithmetic (truncating division, remainder takes
  // the dividend's sign); the 32-bit truncation gives the -2^31/-1 wrap.
  function automatic logic [63:0] ref_div(logic s, logic [31:0] a, logic [31:0] b);
    longint da, db, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    da = s ? longint'($signed(a)) : longint'({32'd0, a});
    db = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = da / db;
    r = da % db;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b, input string name);
    @(negedge clk);
    check({name, " ready_idle"}, 64'(bus.ready), 64'd0);
    bus.start = 1'b1; bus.is_signed = s; bus.opa = a; bus.opb = b; bus.annul = 1'b0;
    #1;
    check({name, " stall_on_start"}, 64'(bus.div_stall), 64'd1);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts negedges after the start edge until ready, bounded.
  task automatic wait_ready(output int cycles, output int stalls, output bit got);
    cycles = 0; stalls = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.ready) got = 1;
      else if (bus.div_stall) stalls++;
    end
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string name);
    int cycles, stalls;
    bit got;
    launch(s, a, b, name);
    wait_ready(cycles, stalls, got);
    check({name, " latency"}, 64'(cycles), 64'(LAT));
    check({name, " stall_cycles"}, 64'(stalls + 1), 64'(LAT));
    check({name, " stall_in_ready"}, 64'(bus.div_stall), 64'd0);
    check({name, " result"}, bus.result, exp);
    last_exp = exp;
  endtask

  initial begin
    int cycles, stalls, ready_seen;
    bit got;
    logic s;
    logic [31:0] a, b;

    vecs[0] = mk(1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},         "udiv_100_7");
    vecs[1] = mk(1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD},  "sdiv_m7_2");
    vecs[2] = mk(1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,          32'hFFFF_FFFD},  "sdiv_7_m2");
    vecs[3] = mk(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,          32'h8000_0000},  "sdiv_ovf");
    vecs[4] = mk(1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0,          32'hFFFF_FFFF},  "udiv_max_1");
    vecs[5] = mk(1'b1, 32'h0000_1234,  32'd0,          {32'h0000_1234,  32'hFFFF_FFFF},  "sdiv_zero");
    vecs[6] = mk(1'b0, 32'h0000_1234,  32'd0,          {32'h0000_1234,  32'hFFFF_FFFF},  "udiv_zero");
    vecs[7] = mk(1'b1, 32'hFFFF_FFF9,  32'd0,          {32'hFFFF_FFF9,  32'hFFFF_FFFF},  "sdiv_neg_zero");
    vecs[8] = mk(1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000,  32'd0},          "udiv_big");

    bus.start = 1'b0; bus.is_signed = 1'b0; bus.opa = '0; bus.opb = '0; bus.annul = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", 64'(bus.ready), 64'd0);
    check("rst stall", 64'(bus.div_stall), 64'd0);
    check("rst result", bus.result, 64'd0);
    rst = 1'b0;

    // start & annul together in IDLE: nothing starts
    @(negedge clk);
    bus.start = 1'b1; bus.annul = 1'b1; bus.opa = 32'd9; bus.opb = 32'd3;
    #1 check("idle_annul stall", 64'(bus.div_stall), 64'd0);
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.annul = 1'b0; end
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready || bus.div_stall) ready_seen++;
    end
    check("idle_annul no_op", 64'(ready_seen), 64'd0);

    // Directed table
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // start during BUSY is ignored
    launch(1'b0, 32'd1000, 32'd3, "busy_start");
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.opa = 32'd55; bus.opb = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_ready(cycles, stalls, got);
    check("busy_start latency", 64'(cycles + 6), 64'(LAT));
    check("busy_start result", bus.result, {32'd1, 32'd333});
    last_exp = {32'd1, 32'd333};

    // Cancel at BUSY cycle 10
    launch(1'b0, 32'd500, 32'd7, "cancel");
    repeat (10) @(negedge clk);
    bus.annul = 1'b1;
    @(posedge clk);
    #1 bus.annul = 1'b0;
    @(negedge clk);
    check("cancel stall", 64'(bus.div_stall), 64'd0);
    check("cancel ready", 64'(bus.ready), 64'd0);
    check("cancel result_kept", bus.result, last_exp);
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready) ready_seen++;
    end
    check("cancel no_ready", 64'(ready_seen), 64'd0);
    run_op(1'b0, 32'd500, 32'd7, {32'd3, 32'd71}, "after_cancel");

    // Asynchronous reset mid-BUSY
    launch(1'b1, 32'hFFFF_0000, 32'd13, "rst_mid");
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid result", bus.result, 64'd0);
    check("rst_mid ready", 64'(bus.ready), 64'd0);
    check("rst_mid stall", 64'(bus.div_stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 32'd12345, 32'd10, ref_div(1'b0, 32'd12345, 32'd10), "b2b_1");
    run_op(1'b1, 32'hFFFF_FF00, 32'd7, ref_div(1'b1, 32'hFFFF_FF00, 32'd7), "b2b_2");
    @(negedge clk);
    check("b2b ready_pulse_width", 64'(bus.ready), 64'd0);

    // Randomized against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: b = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op(s, a, b, ref_div(s, a, b), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "timeout");
  end
endmodule
